// File: rtl/arp_rewrite_if.sv
// AXI4-Stream style bus carrying packet beats with TUSER metadata.
interface arp_rewrite_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/arp_rewrite.sv
// ARP resolution and IPv4 header rewrite stage following the LPM lookup.
// Resolves the next-hop IP to a MAC, rewrites dst MAC / TTL / checksum and
// steers the packet; misses and exceptions are punted to the CPU port.
module arp_rewrite #(
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESET,
    arp_rewrite_if.slave                    s_axis,
    arp_rewrite_if.master                   m_axis,
    input  logic                            lpm_hit,
    input  logic [31:0]                     nh_reg,
    input  logic [31:0]                     oq_reg,
    input  logic                            tbl_wr_req,
    input  logic [4:0]                      tbl_wr_addr,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic                            tbl_rd_req,
    input  logic [4:0]                      tbl_rd_addr,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    output logic                            tbl_wr_ack,
    output logic                            tbl_rd_ack,
    input  logic                            arp_clear,
    output logic [31:0]                     arp_miss_count
);
    localparam int TBL_W  = 4 * C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int FIFO_W = 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_DATA_WIDTH;
    localparam int VLD_BIT = 80;

    typedef enum logic [1:0] {IDLE, LOOKUP, HDR, BODY} state_t;

    // Add 0x0100 to a ones-complement checksum with end-around carry.
    function automatic logic [15:0] csum_inc(input logic [15:0] c);
        logic [16:0] s;
        s = {1'b0, c} + 17'h00100;
        return s[15:0] + {15'd0, s[16]};
    endfunction

    state_t state, state_nxt;

    logic [FIFO_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_cnt;
    logic              fifo_empty, fifo_nearly_full, fifo_wr, fifo_rd;

    logic                            head_last;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user;
    logic [STRB_W-1:0]               head_strb;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  head_data;

    logic [TBL_W-1:0] tbl [32];
    logic             lpm_hit_q, arp_hit_q, arp_hit_c, latch_en;
    logic [31:0]      nh_q, oq_q;
    logic [47:0]      mac_q, mac_c;

    logic                             m_valid, bypass, fwd, exc_hs;
    logic [7:0]                       src_f, dst_f, ttl;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   out_data;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  out_user;

    assign fifo_empty       = (fifo_cnt == 3'd0);
    assign fifo_nearly_full = (fifo_cnt >= 3'd3);
    assign fifo_wr          = s_axis.tvalid & s_axis.tready;
    assign fifo_rd          = m_valid & m_axis.tready;
    assign {head_last, head_user, head_strb, head_data} = fifo_mem[rd_ptr];
    assign s_axis.tready    = !fifo_nearly_full;

    // Input buffer storage; data words are not reset, pointers define content.
    always_ff @(posedge AXI_ACLK) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    end

    // Input buffer pointers and occupancy; reset drops any partial packet.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
            if (fifo_rd) rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'd0, fifo_wr} - {2'd0, fifo_rd};
        end
    end

    // ARP table writes; a write landing at this edge is seen by the next lookup.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            for (int i = 0; i < 32; i++) tbl[i] <= '0;
        end else if (tbl_wr_req) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Register-interface read data and one-cycle acks; reads see pre-write data.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            tbl_rd_data <= '0;
            tbl_wr_ack  <= 1'b0;
            tbl_rd_ack  <= 1'b0;
        end else begin
            tbl_wr_ack <= tbl_wr_req;
            tbl_rd_ack <= tbl_rd_req;
            if (tbl_rd_req) tbl_rd_data <= tbl[tbl_rd_addr];
        end
    end

    // Associative search; scanning downward lets the lowest matching index win.
    always_comb begin
        arp_hit_c = 1'b0;
        mac_c     = '0;
        for (int i = 31; i >= 0; i--) begin
            if (tbl[i][VLD_BIT] && (tbl[i][31:0] == nh_q)) begin
                arp_hit_c = 1'b1;
                mac_c     = tbl[i][79:32];
            end
        end
    end

    // --- stage p0: capture LPM result for the packet at the fifo head
    // --- stage p1: capture lookup result for the header beat
    always_ff @(posedge AXI_ACLK) begin
        if (latch_en) begin
            lpm_hit_q <= lpm_hit;
            nh_q      <= nh_reg;
            oq_q      <= oq_reg;
        end
        if (state == LOOKUP) begin
            arp_hit_q <= arp_hit_c;
            mac_q     <= mac_c;
        end
    end

    // FSM state register.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) state <= IDLE;
        else           state <= state_nxt;
    end

    // FSM next state and stream valid.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        m_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    latch_en  = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: state_nxt = HDR;
            HDR: begin
                m_valid = 1'b1;
                if (m_axis.tready) state_nxt = head_last ? IDLE : BODY;
            end
            BODY: begin
                m_valid = !fifo_empty;
                if (m_valid && m_axis.tready && head_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header rewrite: forward, punt to CPU, or pass untouched.
    always_comb begin
        src_f    = head_user[SRC_PORT_POS +: 8];
        dst_f    = head_user[DST_PORT_POS +: 8];
        ttl      = head_data[79:72];
        bypass   = (dst_f != 8'd0) || ((src_f & 8'hAA) != 8'd0);
        fwd      = lpm_hit_q && arp_hit_q && (oq_q <= 32'd3) && (ttl > 8'd1);
        out_data = head_data;
        out_user = head_user;
        if (state == HDR && !bypass) begin
            if (fwd) begin
                out_data[255:208] = mac_q;
                out_data[79:72]   = ttl - 8'd1;
                out_data[63:48]   = csum_inc(head_data[63:48]);
                out_user[DST_PORT_POS +: 8] = 8'b1 << {oq_q[1:0], 1'b0};
            end else begin
                out_user[DST_PORT_POS +: 8] = src_f << 1;
            end
        end
    end

    assign exc_hs = (state == HDR) && fifo_rd && !bypass && !fwd;

    // Exception counter; clear dominates, saturates at all-ones.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET)                              arp_miss_count <= '0;
        else if (arp_clear)                         arp_miss_count <= '0;
        else if (exc_hs && (arp_miss_count != '1))  arp_miss_count <= arp_miss_count + 32'd1;
    end

    assign m_axis.tdata  = out_data;
    assign m_axis.tstrb  = head_strb;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = head_last;
    assign m_axis.tvalid = m_valid;
endmodule
